// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring unsigned divider, one quotient bit per clock
module seq_divider #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         div0
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_next;
    logic [W-1:0]   dvsr;
    logic [W-1:0]   shreg;
    logic [W-1:0]   prem;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           b_zero;
    logic           last_iter;
    logic [W:0]     p_shift;
    logic [W-1:0]   p_diff;
    logic           q_bit;

    // Stored remainder is always below the divisor, so W bits suffice; only
    // the shifted value needs the extra bit for a non-wrapping compare.
    always_comb begin
        accept    = start && (state != RUN);
        b_zero    = (B == '0);
        last_iter = (cnt == CW'(1));
        p_shift   = {prem, shreg[W-1]};
        q_bit     = (p_shift >= {1'b0, dvsr});
        p_diff    = p_shift[W-1:0] - dvsr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = b_zero ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Q/R are written only on the edge entering DONE, never during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvsr  <= '0;
            shreg <= '0;
            prem  <= '0;
            cnt   <= '0;
            Q     <= '0;
            R     <= '0;
            div0  <= 1'b0;
        end else if (accept) begin
            if (b_zero) begin
                Q    <= '1;
                R    <= A;
                div0 <= 1'b1;
            end else begin
                div0  <= 1'b0;
                dvsr  <= B;
                shreg <= A;
                prem  <= '0;
                cnt   <= CW'(W);
            end
        end else if (state == RUN) begin
            prem  <= q_bit ? p_diff : p_shift[W-1:0];
            shreg <= {shreg[W-2:0], q_bit};
            cnt   <= cnt - CW'(1);
            if (last_iter) begin
                Q <= {shreg[W-2:0], q_bit};
                R <= q_bit ? p_diff : p_shift[W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
module tb_seq_divider;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         div0;

    seq_divider #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .div0  (div0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int d;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ndone    = 0;
    int   nissued  = 0;
    int   last_q   = 0;
    int   last_r   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (rst_n && done) begin
            ndone++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("Q(%0d/%0d)", mon_e.a, mon_e.b), int'(Q), mon_e.q);
                check($sformatf("R(%0d/%0d)", mon_e.a, mon_e.b), int'(R), mon_e.r);
                check($sformatf("div0(%0d/%0d)", mon_e.a, mon_e.b), int'(div0), mon_e.d);
                check($sformatf("latency(%0d/%0d)", mon_e.a, mon_e.b), cyc, mon_e.cyc);
                if (mon_e.b != 0) begin
                    check($sformatf("identity(%0d/%0d)", mon_e.a, mon_e.b),
                          int'(Q) * mon_e.b + int'(R), mon_e.a);
                    check($sformatf("r_lt_b(%0d/%0d)", mon_e.a, mon_e.b),
                          int'(int'(R) < mon_e.b), 1);
                end
                last_q = mon_e.q;
                last_r = mon_e.r;
            end
        end
    end

    function automatic void push(input int a, input int b, input int q, input int r,
                                 input int d, input int acc_cyc);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.q   = q;
        e.r   = r;
        e.d   = d;
        e.cyc = acc_cyc + ((b == 0) ? 0 : W);
        sb.push_back(e);
        nissued++;
    endfunction

    // Called at a negedge; the next posedge is the accepting edge.
    task automatic issue(input int a, input int b, input int q, input int r, input int d);
        start = 1'b1;
        A     = W'(a);
        B     = W'(b);
        push(a, b, q, r, d, cyc + 1);
    endtask

    task automatic wait_done(input int exp_busy);
        int  nb   = 0;
        bit  seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (done) begin
                seen = 1;
            end else begin
                if (busy) nb++;
                check("hold_Q", int'(Q), last_q);
                check("hold_R", int'(R), last_r);
            end
        end
        check("done_seen", int'(seen), 1);
        check("busy_cycles", nb, exp_busy);
    endtask

    initial begin
        int  got;
        int  d0;
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_Q", int'(Q), 0);
        check("rst_R", int'(R), 0);
        check("rst_div0", int'(div0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(13, 3, 4, 1, 0);
        wait_done(W);
        @(negedge clk);
        issue(15, 1, 15, 0, 0);
        wait_done(W);
        @(negedge clk);
        issue(5, 7, 0, 5, 0);
        wait_done(W);
        @(negedge clk);
        issue(9, 0, 15, 9, 1);
        wait_done(0);
        @(negedge clk);
        issue(8, 2, 4, 0, 0);
        wait_done(W);
        issue(7, 7, 1, 0, 0);
        wait_done(W);

        // start held high: mid-run requests ignored, restart taken in DONE
        @(negedge clk);
        start = 1'b1;
        A     = 4'd6;
        B     = 4'd4;
        push(6, 4, 1, 2, 0, cyc + 1);
        got = 0;
        for (int i = 0; i < 30 && got == 0; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                A   = 4'd11;
                B   = 4'd2;
                push(11, 2, 5, 1, 0, cyc + 1);
            end else begin
                A = W'(i + 1);
                B = (i % 2 == 1) ? 4'd0 : 4'd1;
            end
        end
        check("held_first_done", got, 1);
        wait_done(W);

        // asynchronous reset in the second RUN cycle of 14/4
        @(negedge clk);
        start = 1'b1;
        A     = 4'd14;
        B     = 4'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_Q", int'(Q), 0);
        check("abort_R", int'(R), 0);
        check("abort_div0", int'(div0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        d0    = ndone;
        repeat (8) @(negedge clk);
        check("no_done_after_abort", ndone - d0, 0);
        check("abort_Q_stays", int'(Q), 0);
        last_q = 0;
        last_r = 0;
        issue(14, 4, 3, 2, 0);
        wait_done(W);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(negedge clk);
                issue(a, b, (b == 0) ? 15 : a / b, (b == 0) ? a : a % b, (b == 0) ? 1 : 0);
                wait_done((b == 0) ? 0 : W);
            end
        end

        repeat (3) @(negedge clk);
        check("done_count", ndone, nissued);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
